// File: rtl/sprite_anim_sequencer.sv
// Per-player sprite animation sequencer: IDLE/WALK/ATTACK/HIT priority FSM, frame changes
// committed only on frame_tick. Optional macro SPRITE_FACING_EN adds the facing_left register.
module sprite_anim_sequencer #(
    parameter int unsigned SPRITE_PIXELS = 4864,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned FRAME_HOLD    = 6,
    parameter int unsigned WALK_BASE     = 1,
    parameter int unsigned WALK_FRAMES   = 4,
    parameter int unsigned ATTACK_BASE   = 5,
    parameter int unsigned ATTACK_FRAMES = 2,
    parameter int unsigned HIT_BASE      = 7,
    parameter int unsigned HIT_FRAMES    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  move_left,
    input  logic                  move_right,
    input  logic                  attack_req,
    input  logic                  hit,
    output logic [2:0]            sprite_select,
    output logic [ADDR_WIDTH-1:0] rom_base,
    output logic                  busy,
    output logic                  anim_done,
    output logic                  facing_left
);

    localparam int unsigned HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(FRAME_HOLD - 1);
    localparam logic [2:0] WALK_LAST = 3'(WALK_FRAMES - 1);
    localparam logic [2:0] ATK_LAST  = 3'(ATTACK_FRAMES - 1);
    localparam logic [2:0] HIT_LAST  = 3'(HIT_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StWalk, StAttack, StHit} state_e;

    state_e          state_q, state_d;
    logic [2:0]      frame_q, frame_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            pend_atk_q, pend_atk_d;
    logic            pend_hit_q, pend_hit_d;
    logic            done_d;
    logic [2:0]      sel_d;
    logic [31:0]     prod;
    logic            move, in_anim, atk_now, hit_now;
    logic [2:0]      last;

    always_comb begin
        move       = move_left ^ move_right;
        in_anim    = (state_q == StAttack) || (state_q == StHit);
        // Attack requests are dropped outright while an animation is playing.
        atk_now    = pend_atk_q | (attack_req & ~in_anim);
        hit_now    = pend_hit_q | hit;
        last       = (state_q == StAttack) ? ATK_LAST : HIT_LAST;
        state_d    = state_q;
        frame_d    = frame_q;
        hold_d     = hold_q;
        pend_atk_d = atk_now;
        pend_hit_d = hit_now;
        done_d     = 1'b0;

        if (frame_tick) begin
            pend_atk_d = 1'b0;
            pend_hit_d = 1'b0;
            if (hit_now) begin
                state_d = StHit;
                frame_d = '0;
                hold_d  = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (atk_now || move) begin
                            state_d = atk_now ? StAttack : StWalk;
                            frame_d = '0;
                            hold_d  = '0;
                        end
                    end
                    StWalk: begin
                        if (atk_now || !move) begin
                            state_d = atk_now ? StAttack : StIdle;
                            frame_d = '0;
                            hold_d  = '0;
                        end else if (hold_q < HOLD_LAST) begin
                            hold_d = hold_q + 1'b1;
                        end else begin
                            hold_d  = '0;
                            frame_d = (frame_q == WALK_LAST) ? 3'd0 : frame_q + 3'd1;
                        end
                    end
                    StAttack, StHit: begin
                        if (hold_q < HOLD_LAST) begin
                            hold_d = hold_q + 1'b1;
                        end else begin
                            hold_d = '0;
                            if (frame_q == last) begin
                                state_d = move ? StWalk : StIdle;
                                frame_d = '0;
                                done_d  = 1'b1;
                            end else begin
                                frame_d = frame_q + 3'd1;
                            end
                        end
                    end
                endcase
            end
        end

        unique case (state_d)
            StIdle:   sel_d = 3'd0;
            StWalk:   sel_d = 3'(WALK_BASE) + frame_d;
            StAttack: sel_d = 3'(ATTACK_BASE) + frame_d;
            StHit:    sel_d = 3'(HIT_BASE) + frame_d;
        endcase
        prod = 32'(sel_d) * 32'(SPRITE_PIXELS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            frame_q       <= '0;
            hold_q        <= '0;
            pend_atk_q    <= 1'b0;
            pend_hit_q    <= 1'b0;
            sprite_select <= '0;
            rom_base      <= '0;
            busy          <= 1'b0;
            anim_done     <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            hold_q        <= hold_d;
            pend_atk_q    <= pend_atk_d;
            pend_hit_q    <= pend_hit_d;
            sprite_select <= sel_d;
            rom_base      <= prod[ADDR_WIDTH-1:0];
            busy          <= (state_d == StAttack) || (state_d == StHit);
            anim_done     <= done_d;
        end
    end

`ifdef SPRITE_FACING_EN
    logic facing_q;

    // Direction is frozen while an attack or hit animation plays.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            facing_q <= 1'b0;
        end else if (frame_tick && !in_anim) begin
            if (move_left && !move_right) begin
                facing_q <= 1'b1;
            end else if (move_right && !move_left) begin
                facing_q <= 1'b0;
            end
        end
    end

    assign facing_left = facing_q;
`else
    assign facing_left = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed self-checking bench for sprite_anim_sequencer with FRAME_HOLD=2.
module tb_sprite_anim_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        move_left = 1'b0;
    logic        move_right = 1'b0;
    logic        attack_req = 1'b0;
    logic        hit = 1'b0;
    logic [2:0]  sprite_select;
    logic [15:0] rom_base;
    logic        busy;
    logic        anim_done;
    logic        facing_left;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

`ifdef SPRITE_FACING_EN
    localparam logic FACE_EXP = 1'b1;
`else
    localparam logic FACE_EXP = 1'b0;
`endif

    sprite_anim_sequencer #(.FRAME_HOLD(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .move_left    (move_left),
        .move_right   (move_right),
        .attack_req   (attack_req),
        .hit          (hit),
        .sprite_select(sprite_select),
        .rom_base     (rom_base),
        .busy         (busy),
        .anim_done    (anim_done),
        .facing_left  (facing_left)
    );

    always #5 clk = ~clk;

    // Pulse frame_tick now; sample the committed outputs at the following negedge.
    task automatic tick_now();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        attack_req = 1'b0;
        hit = 1'b0;
        if (anim_done === 1'b1) done_seen++;
    endtask

    task automatic tick();
        repeat (3) @(negedge clk);
        tick_now();
    endtask

    task automatic pulse_attack();
        @(negedge clk);
        attack_req = 1'b1;
        @(negedge clk);
        attack_req = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [2:0] sel, input logic bsy);
        checks++;
        if (sprite_select !== sel || rom_base !== 16'(sel * 4864) || busy !== bsy) begin
            errors++;
            $display("FAIL %s: sel=%0d rom=%0d busy=%b, required sel=%0d rom=%0d busy=%b",
                     name, sprite_select, rom_base, busy, sel, sel * 4864, bsy);
        end
    endtask

    task automatic check_done(input string name, input int exp);
        checks++;
        if (done_seen !== exp) begin
            errors++;
            $display("FAIL %s: anim_done pulses=%0d, required %0d", name, done_seen, exp);
        end
        done_seen = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_out("reset_outputs", 3'd0, 1'b0);
        checks++;
        if (anim_done !== 1'b0 || facing_left !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: anim_done=%b facing=%b, required 0 0", anim_done, facing_left);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_walk();
        logic [2:0] exp [10] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd1, 3'd1};
        move_right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out($sformatf("walk_tick%0d", i), exp[i], 1'b0);
        end
    endtask

    task automatic test_reset_mid_walk();
        reset = 1'b1;
        #1;
        check_out("async_reset_mid_walk", 3'd0, 1'b0);
        move_right = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_tick();
        move_right = 1'b1;
        repeat (20) @(negedge clk);
        check_out("no_tick_constant", 3'd0, 1'b0);
        move_right = 1'b0;
    endtask

    task automatic test_attack();
        logic [2:0] exp [5] = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd0};
        logic       bsy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        done_seen = 0;
        pulse_attack();
        repeat (3) @(negedge clk);
        tick_now();
        check_out("attack_f0", exp[0], bsy[0]);
        pulse_attack();
        for (int i = 1; i < 5; i++) begin
            tick();
            check_out($sformatf("attack_step%0d", i), exp[i], bsy[i]);
        end
        check_done("attack_done_once", 1);
        @(negedge clk);
        checks++;
        if (anim_done !== 1'b0) begin
            errors++;
            $display("FAIL attack_done_width: anim_done=%b, required 0", anim_done);
        end
        tick();
        check_out("attack_req_ignored", 3'd0, 1'b0);
    endtask

    task automatic test_hit_during_attack();
        pulse_attack();
        tick();
        tick();
        tick();
        check_out("pre_hit_attack_f1", 3'd6, 1'b1);
        @(negedge clk);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        done_seen = 0;
        tick();
        check_out("hit_f0", 3'd7, 1'b1);
        tick();
        check_out("hit_hold", 3'd7, 1'b1);
        move_right = 1'b1;
        tick();
        check_out("hit_end_walk", 3'd1, 1'b0);
        check_done("hit_done_once", 1);
        move_right = 1'b0;
        tick();
        check_out("walk_release_idle", 3'd0, 1'b0);
    endtask

    task automatic test_both_moves();
        move_left = 1'b1;
        move_right = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("both_moves%0d", i), 3'd0, 1'b0);
        end
        move_right = 1'b0;
        tick();
        check_out("left_walk", 3'd1, 1'b0);
        move_left = 1'b0;
        tick();
        check_out("left_release_idle", 3'd0, 1'b0);
        checks++;
        if (facing_left !== FACE_EXP) begin
            errors++;
            $display("FAIL facing_held: facing_left=%b, required %b", facing_left, FACE_EXP);
        end
    endtask

    task automatic test_hit_beats_attack();
        @(negedge clk);
        attack_req = 1'b1;
        hit = 1'b1;
        @(negedge clk);
        attack_req = 1'b0;
        hit = 1'b0;
        done_seen = 0;
        tick();
        check_out("both_pulses_hit", 3'd7, 1'b1);
        tick();
        tick();
        check_out("both_pulses_end", 3'd0, 1'b0);
        check_done("both_pulses_done", 1);
        tick();
        check_out("no_attack_after_hit", 3'd0, 1'b0);
    endtask

    task automatic test_coincident_attack();
        logic [2:0] exp [4] = '{3'd5, 3'd6, 3'd6, 3'd0};
        repeat (2) @(negedge clk);
        attack_req = 1'b1;
        tick_now();
        check_out("coincident_attack", 3'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("coincident_step%0d", i), exp[i], i < 3);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_reset_mid_walk();
        test_no_tick();
        test_attack();
        test_hit_during_attack();
        test_both_moves();
        test_hit_beats_attack();
        test_coincident_attack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_anim_sequencer.md
Name: sprite_anim_sequencer

Overview:
- Per-player animation controller that drives the sprite renderer's frame selection: sprite_select plus the matching ROM base address.
- Runs a priority state machine (IDLE/WALK/ATTACK/HIT) from player input and game events.
- Commits frame changes only on the per-video-frame tick, so a sprite never changes mid-scan.
- One instance per player, between game logic and the sprite renderer/ROM.

Parameters:
- SPRITE_PIXELS, 4864, pixels per sprite frame (76*64); base address stride.
- ADDR_WIDTH, 16, width of rom_base.
- FRAME_HOLD, 6, frame ticks each animation frame is displayed (>=1).
- WALK_BASE, 1, sprite_select of first walk frame.
- WALK_FRAMES, 4, walk loop length.
- ATTACK_BASE, 5, sprite_select of first attack frame.
- ATTACK_FRAMES, 2, attack length.
- HIT_BASE, 7, sprite_select of first hit frame.
- HIT_FRAMES, 1, hit-stun length.
- Idle frame is fixed at sprite_select 0.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-clk pulse per video frame (end of active area)
- move_left  in  1  level, player holds left
- move_right  in  1  level, player holds right
- attack_req  in  1  one-clk pulse, attack requested
- hit  in  1  one-clk pulse, player was struck
- sprite_select  out  3  current frame index to renderer
- rom_base  out  ADDR_WIDTH  sprite_select*SPRITE_PIXELS
- busy  out  1  high in ATTACK or HIT
- anim_done  out  1  one-clk pulse when ATTACK or HIT completes
- facing_left  out  1  facing direction (see Optional Feature)

Behaviour:
- Reset (async, active-high): state=IDLE, frame_idx=0, hold_cnt=0, pend_atk=0, pend_hit=0, sprite_select=0, rom_base=0, busy=0, anim_done=0, facing_left=0. Reset mid-animation aborts to IDLE immediately.
- Pending latches: attack_req sets pend_atk; hit sets pend_hit. Both hold until consumed at the next frame_tick, which clears them. attack_req arriving while in ATTACK or HIT is discarded (pend_atk not set). A pulse coincident with frame_tick is consumed at that tick.
- move = move_left XOR move_right. Both held counts as no move.
- All state, frame_idx and hold_cnt updates happen only on a clk where frame_tick=1. Outputs are registered and change 1 clk after that edge.
- Transitions on tick, in priority order:
  - pend_hit: go to HIT from any state, including HIT (restart). frame_idx=0, hold_cnt=0.
  - In ATTACK: non-interruptible except by hit.
  - In HIT: non-interruptible except by a new hit.
  - pend_atk in IDLE/WALK: go to ATTACK, frame_idx=0, hold_cnt=0.
  - IDLE with move: go to WALK, frame_idx=0, hold_cnt=0.
  - WALK with no move: go to IDLE on that tick, frame_idx=0.
- Frame advance, on a tick with no transition:
  - If hold_cnt<FRAME_HOLD-1, hold_cnt+1.
  - Else hold_cnt=0 and advance frame_idx.
  - WALK: frame_idx wraps WALK_FRAMES-1 -> 0.
  - ATTACK/HIT: advancing past the last frame ends the animation. Next state is WALK if move, else IDLE; frame_idx=0; anim_done pulses 1 clk.
- sprite_select: IDLE=0, WALK=WALK_BASE+frame_idx, ATTACK=ATTACK_BASE+frame_idx, HIT=HIT_BASE+frame_idx.
- rom_base is computed from the next sprite_select and registered in the same clk, so it is always consistent with sprite_select. Product truncated to ADDR_WIDTH.
- busy reflects the registered state.
- frame_tick never asserted: outputs stay constant.

Optional Feature:
- Macro: SPRITE_FACING_EN.
- Defined: facing_left register updates on a tick in IDLE/WALK. Set to 1 if move_left&~move_right, cleared to 0 if move_right&~move_left, otherwise held. It is frozen during ATTACK/HIT. Reset value 0.
- Undefined: facing_left tied to 0; no register synthesized.

Test Plan:
- FRAME_HOLD=2. Assert reset mid-WALK -> next cycle sprite_select=0, rom_base=0, busy=0, with no clk edge needed.
- Hold move_right for 10 ticks -> sprite_select sequence 1,1,2,2,3,3,4,4,1,1. rom_base tracks 4864*sel, e.g. sel=3 gives 14592.
- From IDLE, pulse attack_req 5 clk before a tick:
  - sprite_select 5,5,6,6, then 0.
  - anim_done pulses once on the return to idle.
  - busy high throughout; a second attack_req during ATTACK is ignored.
- During ATTACK frame 6, pulse hit -> next tick sprite_select=7, busy=1. After 2 ticks, returns to 0 (or walk frame 1 if move held), with an anim_done pulse.
- Hold move_left and move_right together from IDLE -> stays sprite_select=0. With SPRITE_FACING_EN, move_left alone then release -> facing_left=1 and held.
- attack_req and hit pulsed together, both before the same tick -> HIT wins. pend_atk is cleared and no ATTACK follows.
